// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Requester-side bundle for sram_arbiter. It carries the two request ports and
// the shared busy flag.
//   I_req*/I_we*/I_addr*/I_wdata*  requester -> arbiter
//   O_ack*/O_rdata*                arbiter -> requester
//   O_busy                         arbiter -> requester
// Modports:
//   slave   the arbiter side of the bundle
//   master  the requester (or bench) side of the bundle
interface sram_arbiter_if #(
    parameter int pDATA_WIDTH = 8,
    parameter int pADDR_WIDTH = 20
);
    logic                   I_req0;
    logic                   I_req1;
    logic                   I_we0;
    logic                   I_we1;
    logic [pADDR_WIDTH-1:0] I_addr0;
    logic [pADDR_WIDTH-1:0] I_addr1;
    logic [pDATA_WIDTH-1:0] I_wdata0;
    logic [pDATA_WIDTH-1:0] I_wdata1;
    logic                   O_ack0;
    logic                   O_ack1;
    logic [pDATA_WIDTH-1:0] O_rdata0;
    logic [pDATA_WIDTH-1:0] O_rdata1;
    logic                   O_busy;

    modport slave (
        input  I_req0, I_req1, I_we0, I_we1, I_addr0, I_addr1, I_wdata0, I_wdata1,
        output O_ack0, O_ack1, O_rdata0, O_rdata1, O_busy
    );

    modport master (
        output I_req0, I_req1, I_we0, I_we1, I_addr0, I_addr1, I_wdata0, I_wdata1,
        input  O_ack0, O_ack1, O_rdata0, O_rdata1, O_busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Lets two requesters share one external asynchronous SRAM. Port 0 is the host
// register bridge and port 1 is the test/capture engine. The block arbitrates
// round-robin between them and sequences each access with fixed strobe widths.
// Completion is signalled with a one-cycle ack; on a read, the data is returned
// at the same time.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   req_if       requester bundle (sram_arbiter_if.slave)
//   cen, ce2     SRAM CE# (active-low) and CE2 (always ~cen)
//   wen, oen     SRAM WE# and OE# (active-low)
//   addr         SRAM address
//   data         SRAM data bus; driven only while drive_en is high
//
// state   | meaning
// IDLE    | bus released, strobes high, waiting for a request
// SETUP   | chip enabled, address settling, no strobe
// WRITE   | WE# low, captured write data on the bus
// READ    | OE# low, bus released; sampled on the last cycle
// RECOVER | strobes high, ack pulse; a write keeps data driven one more cycle
module sram_arbiter #(
    parameter int pDATA_WIDTH = 8,
    parameter int pADDR_WIDTH = 20,
    parameter int pWR_CYCLES  = 3,
    parameter int pRD_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    sram_arbiter_if.slave          req_if,
    output logic                   cen,
    output logic                   ce2,
    output logic                   wen,
    output logic                   oen,
    output logic [pADDR_WIDTH-1:0] addr,
    inout  wire  [pDATA_WIDTH-1:0] data
);
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, READ, RECOVER} state_t;

    localparam logic [3:0] WR_LAST = 4'(pWR_CYCLES - 1);
    localparam logic [3:0] RD_LAST = 4'(pRD_CYCLES - 1);

    state_t                 state_q,  state_d;
    logic [3:0]             cnt_q,    cnt_d;
    logic                   grant_q,  grant_d;
    logic                   last_q,   last_d;
    logic                   we_q,     we_d;
    logic [pADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [pDATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [pDATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [pDATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                   drive_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;   // port 0 wins the first tie after reset
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req_if.I_req0 || req_if.I_req1) begin
                    // On a tie, the port that was not granted last time wins.
                    grant_d = (req_if.I_req0 && req_if.I_req1) ? ~last_q : req_if.I_req1;
                    we_d    = grant_d ? req_if.I_we1    : req_if.I_we0;
                    addr_d  = grant_d ? req_if.I_addr1  : req_if.I_addr0;
                    wdata_d = grant_d ? req_if.I_wdata1 : req_if.I_wdata0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = we_q ? WRITE : READ;
            end
            WRITE: begin
                if (cnt_q == WR_LAST) state_d = RECOVER;
                else                  cnt_d   = cnt_q + 4'd1;
            end
            READ: begin
                if (cnt_q == RD_LAST) begin
                    if (grant_q) rdata1_d = data;
                    else         rdata0_d = data;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECOVER: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cen             = !(state_q == SETUP || state_q == WRITE || state_q == READ);
        ce2             = ~cen;
        wen             = (state_q != WRITE);
        oen             = (state_q != READ);
        addr            = addr_q;
        // Holding data through RECOVER gives hold time past the WE# rising edge.
        drive_en        = (state_q == WRITE) || (state_q == RECOVER && we_q);
        req_if.O_ack0   = (state_q == RECOVER) && !grant_q;
        req_if.O_ack1   = (state_q == RECOVER) &&  grant_q;
        req_if.O_rdata0 = rdata0_q;
        req_if.O_rdata1 = rdata1_q;
        req_if.O_busy   = (state_q != IDLE);
    end

    assign data = drive_en ? wdata_q : {pDATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter. Instance A uses the default strobe widths, and
// instance B uses pWR_CYCLES=1 with pRD_CYCLES=15. Each instance is connected
// to a small SRAM model.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A (defaults) ----------------
    sram_arbiter_if #(.pDATA_WIDTH(8), .pADDR_WIDTH(20)) ifa();
    logic        cen_a, ce2_a, wen_a, oen_a;
    logic [19:0] addr_a;
    wire  [7:0]  data_a;
    logic [7:0]  mem_a [256];

    sram_arbiter #(.pDATA_WIDTH(8), .pADDR_WIDTH(20), .pWR_CYCLES(3), .pRD_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .req_if(ifa.slave),
        .cen(cen_a), .ce2(ce2_a), .wen(wen_a), .oen(oen_a), .addr(addr_a), .data(data_a)
    );

    assign data_a = (!cen_a && !oen_a) ? mem_a[addr_a[7:0]] : 8'hzz;
    always @(posedge clk) if (!cen_a && !wen_a) mem_a[addr_a[7:0]] <= data_a;

    // ---------------- instance B (1 / 15) ----------------
    sram_arbiter_if #(.pDATA_WIDTH(8), .pADDR_WIDTH(20)) ifb();
    logic        cen_b, ce2_b, wen_b, oen_b;
    logic [19:0] addr_b;
    wire  [7:0]  data_b;
    logic [7:0]  mem_b [256];

    sram_arbiter #(.pDATA_WIDTH(8), .pADDR_WIDTH(20), .pWR_CYCLES(1), .pRD_CYCLES(15)) dut_b (
        .clk(clk), .reset(reset), .req_if(ifb.slave),
        .cen(cen_b), .ce2(ce2_b), .wen(wen_b), .oen(oen_b), .addr(addr_b), .data(data_b)
    );

    assign data_b = (!cen_b && !oen_b) ? mem_b[addr_b[7:0]] : 8'hzz;
    always @(posedge clk) if (!cen_b && !wen_b) mem_b[addr_b[7:0]] <= data_b;

    // ---------------- continuous bus checks ----------------
    logic mon_en = 1'b0;
    logic wen_lo_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk_eq("drive_timing", 32'(dut_a.drive_en), 32'(reset ? 1'b0 : (!wen_a || wen_lo_prev)));
            chk_eq("no_contention_a", 32'(dut_a.drive_en & !oen_a), 32'd0);
            chk_eq("no_contention_b", 32'(dut_b.drive_en & !oen_b), 32'd0);
            chk_eq("ce2_a", 32'(ce2_a), 32'(!cen_a));
            chk_eq("ack_overlap", 32'(ifa.O_ack0 & ifa.O_ack1), 32'd0);
        end
        wen_lo_prev <= !wen_a;
    end

    // ---------------- stimulus helpers ----------------
    // A single access on instance A. The cycle number follows the access timing,
    // where cycle 1 is SETUP.
    task automatic acc_a(input bit port, input bit we, input logic [19:0] a, input logic [7:0] wd,
                         output int lat, output int wlo, output int olo, output logic [7:0] rd);
        @(posedge clk); #1;
        if (port) begin
            ifa.I_we1 = we; ifa.I_addr1 = a; ifa.I_wdata1 = wd; ifa.I_req1 = 1'b1;
        end else begin
            ifa.I_we0 = we; ifa.I_addr0 = a; ifa.I_wdata0 = wd; ifa.I_req0 = 1'b1;
        end
        lat = 0; wlo = 0; olo = 0; rd = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (!wen_a) wlo++;
            if (!oen_a) olo++;
            if (port ? ifa.O_ack1 : ifa.O_ack0) begin
                lat = n;
                rd  = port ? ifa.O_rdata1 : ifa.O_rdata0;
                break;
            end
        end
        ifa.I_req0 = 1'b0;
        ifa.I_req1 = 1'b0;
    endtask

    task automatic acc_b(input bit we, input logic [19:0] a, input logic [7:0] wd,
                         output int lat, output logic [7:0] rd);
        @(posedge clk); #1;
        ifb.I_we0 = we; ifb.I_addr0 = a; ifb.I_wdata0 = wd; ifb.I_req0 = 1'b1;
        lat = 0; rd = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (ifb.O_ack0) begin
                lat = n;
                rd  = ifb.O_rdata0;
                break;
            end
        end
        ifb.I_req0 = 1'b0;
    endtask

    logic [7:0] lfsr_v [16];

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Port 1 keeps req high for 16 back-to-back accesses. The inputs advance on
    // each ack.
    task automatic stream1(input bit we);
        int idx;
        int idle_run;
        idx = 0;
        idle_run = 0;
        @(posedge clk); #1;
        ifa.I_we1 = we; ifa.I_addr1 = '0; ifa.I_wdata1 = lfsr_v[0]; ifa.I_req1 = 1'b1;
        for (int n = 0; n < 200 && idx < 16; n++) begin
            @(negedge clk);
            if (!ifa.O_busy) idle_run++;
            if (ifa.O_ack1) begin
                if (!we) chk_eq("stream_rdata", 32'(ifa.O_rdata1), 32'(lfsr_v[idx]));
                if (idx > 0) chk_eq("stream_gap", 32'(idle_run), 32'd1);
                idle_run = 0;
                idx++;
                if (idx < 16) begin
                    ifa.I_addr1  = 20'(idx);
                    ifa.I_wdata1 = lfsr_v[idx];
                end
            end
        end
        ifa.I_req1 = 1'b0;
        chk_eq(we ? "stream_wr_count" : "stream_rd_count", 32'(idx), 32'd16);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, wlo, olo, nacks, ackseen;
        int tie_order [4];
        int tie_last_cyc;
        logic [7:0] rd;

        ifa.I_req0 = 0; ifa.I_req1 = 0; ifa.I_we0 = 0; ifa.I_we1 = 0;
        ifa.I_addr0 = '0; ifa.I_addr1 = '0; ifa.I_wdata0 = '0; ifa.I_wdata1 = '0;
        ifb.I_req0 = 0; ifb.I_req1 = 0; ifb.I_we0 = 0; ifb.I_we1 = 0;
        ifb.I_addr0 = '0; ifb.I_addr1 = '0; ifb.I_wdata0 = '0; ifb.I_wdata1 = '0;
        lfsr_v[0] = 8'h01;
        for (int i = 1; i < 16; i++) lfsr_v[i] = lfsr_next(lfsr_v[i-1]);

        // Reset values
        repeat (2) @(negedge clk);
        chk_eq("rst_cen",    32'(cen_a), 32'd1);
        chk_eq("rst_ce2",    32'(ce2_a), 32'd0);
        chk_eq("rst_wen",    32'(wen_a), 32'd1);
        chk_eq("rst_oen",    32'(oen_a), 32'd1);
        chk_eq("rst_addr",   32'(addr_a), 32'd0);
        chk_eq("rst_drive",  32'(dut_a.drive_en), 32'd0);
        chk_eq("rst_ack0",   32'(ifa.O_ack0), 32'd0);
        chk_eq("rst_ack1",   32'(ifa.O_ack1), 32'd0);
        chk_eq("rst_rdata0", 32'(ifa.O_rdata0), 32'd0);
        chk_eq("rst_rdata1", 32'(ifa.O_rdata1), 32'd0);
        chk_eq("rst_busy",   32'(ifa.O_busy), 32'd0);
        #2 reset = 1'b0;
        mon_en = 1'b1;

        // Tie from reset: grants alternate 0,1,0,1. Each write is 6 cycles long.
        @(posedge clk); #1;
        ifa.I_we0 = 1; ifa.I_addr0 = 20'h00020; ifa.I_wdata0 = 8'h11;
        ifa.I_we1 = 1; ifa.I_addr1 = 20'h00021; ifa.I_wdata1 = 8'h22;
        ifa.I_req0 = 1; ifa.I_req1 = 1;
        nacks = 0;
        tie_last_cyc = 0;
        for (int n = 1; n <= 60 && nacks < 4; n++) begin
            @(posedge clk); @(negedge clk);
            if (ifa.O_ack0 || ifa.O_ack1) begin
                tie_order[nacks] = ifa.O_ack1 ? 1 : 0;
                nacks++;
                tie_last_cyc = n;
            end
        end
        ifa.I_req0 = 0; ifa.I_req1 = 0;
        chk_eq("tie_nacks", 32'(nacks), 32'd4);
        chk_eq("tie_grant0", 32'(tie_order[0]), 32'd0);
        chk_eq("tie_grant1", 32'(tie_order[1]), 32'd1);
        chk_eq("tie_grant2", 32'(tie_order[2]), 32'd0);
        chk_eq("tie_grant3", 32'(tie_order[3]), 32'd1);
        chk_eq("tie_4th_ack_cycle", 32'(tie_last_cyc), 32'd23);
        acc_a(0, 0, 20'h00020, 8'h00, lat, wlo, olo, rd);
        chk_eq("tie_rd_p0", 32'(rd), 32'h11);
        acc_a(0, 0, 20'h00021, 8'h00, lat, wlo, olo, rd);
        chk_eq("tie_rd_p1", 32'(rd), 32'h22);

        // Port 0 writes, then reads back the same location.
        acc_a(0, 1, 20'h00010, 8'hA5, lat, wlo, olo, rd);
        chk_eq("wr_ack_cycle", 32'(lat), 32'd5);
        chk_eq("wr_wen_low", 32'(wlo), 32'd3);
        acc_a(0, 0, 20'h00010, 8'h00, lat, wlo, olo, rd);
        chk_eq("rd_ack_cycle", 32'(lat), 32'd6);
        chk_eq("rd_oen_low", 32'(olo), 32'd4);
        chk_eq("rd_data", 32'(rd), 32'hA5);
        @(negedge clk);
        chk_eq("ack_one_cycle", 32'(ifa.O_ack0), 32'd0);
        repeat (3) @(negedge clk);
        chk_eq("rdata_held", 32'(ifa.O_rdata0), 32'hA5);

        // Port 1 streams LFSR writes, then reads them back.
        stream1(1'b1);
        stream1(1'b0);

        // Reset in the middle of a write
        @(posedge clk); #1;
        ifa.I_we0 = 1; ifa.I_addr0 = 20'h00030; ifa.I_wdata0 = 8'h5A; ifa.I_req0 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("mid_in_write", 32'(wen_a), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk_eq("mid_rst_cen",   32'(cen_a), 32'd1);
        chk_eq("mid_rst_wen",   32'(wen_a), 32'd1);
        chk_eq("mid_rst_oen",   32'(oen_a), 32'd1);
        chk_eq("mid_rst_drive", 32'(dut_a.drive_en), 32'd0);
        chk_eq("mid_rst_ack0",  32'(ifa.O_ack0), 32'd0);
        chk_eq("mid_rst_busy",  32'(ifa.O_busy), 32'd0);
        ackseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ifa.O_ack0) ackseen++;
        end
        ifa.I_req0 = 0;
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ifa.O_ack0) ackseen++;
        end
        chk_eq("mid_rst_no_ack", 32'(ackseen), 32'd0);
        acc_a(0, 0, 20'h00010, 8'h00, lat, wlo, olo, rd);
        chk_eq("post_rst_rd_cycle", 32'(lat), 32'd6);
        chk_eq("post_rst_rd_data", 32'(rd), 32'hA5);

        // Instance B: the write ack is in cycle 3, giving a period of 4. The
        // read ack is in cycle 17, giving a period of 18.
        acc_b(1, 20'h00005, 8'h3C, lat, rd);
        chk_eq("b_wr_cycle", 32'(lat), 32'd3);
        acc_b(1, 20'h00006, 8'hC3, lat, rd);
        chk_eq("b_wr2_cycle", 32'(lat), 32'd3);
        acc_b(0, 20'h00005, 8'h00, lat, rd);
        chk_eq("b_rd_cycle", 32'(lat), 32'd17);
        chk_eq("b_rd_data", 32'(rd), 32'h3C);
        acc_b(0, 20'h00006, 8'h00, lat, rd);
        chk_eq("b_rd2_data", 32'(rd), 32'hC3);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external asynchronous SRAM (CE#/CE2/WE#/OE#, tri-state data bus) between two requesters: port 0, the host register bridge, and port 1, the on-board test/capture engine. It sits between those requesters and the SRAM pins. It arbitrates round-robin, sequences each access with programmable strobe widths, and returns read data with a one-cycle acknowledge pulse.

## Interface
Parameters:
- pDATA_WIDTH, 8, SRAM data width
- pADDR_WIDTH, 20, SRAM address width
- pWR_CYCLES, 3, cycles WE# is held low per write; legal range 1..15
- pRD_CYCLES, 4, cycles OE# is held low per read; legal range 1..15

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- I_req0 / I_req1  in  1  access request; hold high until the matching ack
- I_we0 / I_we1  in  1  1 = write, 0 = read; stable while req is high
- I_addr0 / I_addr1  in  pADDR_WIDTH  access address
- I_wdata0 / I_wdata1  in  pDATA_WIDTH  write data
- O_ack0 / O_ack1  out  1  one-cycle completion pulse
- O_rdata0 / O_rdata1  out  pDATA_WIDTH  read data; valid during ack, held until the next read on that port
- O_busy  out  1  high in any state other than IDLE
- cen  out  1  SRAM CE#, active-low
- ce2  out  1  SRAM CE2; always equal to ~cen
- wen  out  1  SRAM WE#, active-low
- oen  out  1  SRAM OE#, active-low
- addr  out  pADDR_WIDTH  SRAM address
- data  inout  pDATA_WIDTH  SRAM data bus; driven only while the internal drive enable is high

## Operation
- States: IDLE, SETUP, WRITE, READ, RECOVER.
- IDLE: cen=wen=oen=1, bus hi-Z. If either req is high, grant one port and go to SETUP. On grant, register addr, we and wdata from the granted port.
- Arbitration: a lone requester wins. If both request, the port not granted last wins. The last-grant pointer resets to "port 1", so port 0 wins the first tie.
- SETUP (1 cycle): cen=0, addr valid, wen=oen=1, bus hi-Z. Go to WRITE if we=1, otherwise READ. Load the strobe counter with 0.
- WRITE (pWR_CYCLES cycles): cen=0, wen=0, bus driven with the captured wdata. Exit to RECOVER when the counter reaches pWR_CYCLES-1.
- READ (pRD_CYCLES cycles): cen=0, oen=0, bus hi-Z. On the last cycle (counter = pRD_CYCLES-1), sample data into the granted port's rdata register, then go to RECOVER.
- RECOVER (1 cycle): cen=wen=oen=1. After a write the bus stays driven this cycle (data hold past the WE# rising edge), then releases. Pulse the granted port's ack. Update the last-grant pointer. Return to IDLE.
- The arbiter never drives data while oen=0.
- Requests are evaluated only in IDLE. Dropping req mid-access does not abort; the access completes and ack still pulses.
- addr, wdata and we are captured at grant. Later changes on a port's inputs do not affect the access in flight.

## Timing
- Reset values (applied asynchronously): state=IDLE, cen=wen=oen=1, ce2=0, addr=0, bus hi-Z, O_ack0=O_ack1=0, O_rdata0=O_rdata1=0, O_busy=0, last-grant pointer = port 1.
- Let edge 0 be the clock edge at which IDLE sees req.
  - SETUP occupies cycle 1.
  - A write spans cycles 2..pWR_CYCLES+1, with ack in cycle pWR_CYCLES+2.
  - A read spans cycles 2..pRD_CYCLES+1, with ack and rdata valid in cycle pRD_CYCLES+2.
- Access period: pWR_CYCLES+3 cycles per write and pRD_CYCLES+3 per read, including the IDLE cycle. Defaults give 6 and 7.
- A requester must drop req in the cycle after ack. If req is still high, it is treated as a new request; this is legal for back-to-back streaming.
- Reset asserted mid-access releases the bus, deasserts all strobes and suppresses ack immediately. The interrupted access is lost.
- The strobe counter is 4 bits and is compared for equality only; there is no wrap-around inside legal parameter ranges.

## Test plan
- Port 0 write 0xA5 to 0x00010, then read it back, defaults (SRAM model) -> wen low for exactly 3 cycles, ack0 in cycle 5 after req, read ack0 in cycle 6 with rdata0=0xA5.
- I_req0 and I_req1 both rising in the same cycle, held continuously -> grant order 0,1,0,1; each ack pulses once per access; no overlap of cen-low windows.
- Port 1 streams 16 writes of an LFSR sequence to addresses 0..15, then reads them back -> all rdata1 match; O_busy is low for exactly one cycle between accesses.
- Reset asserted during WRITE (cycle 3) -> same-cycle cen=wen=1, bus hi-Z, no ack; after release, a fresh port 0 read completes normally.
- Bus contention check across every write-to-read turnaround -> the data drive enable is never high while oen=0; a write's data stays driven exactly one cycle after wen rises.
- Rebuild with pWR_CYCLES=1 and pRD_CYCLES=15 -> write period 4 cycles, read period 18 cycles, data correct.
